// File: rtl/npc_pkg.sv
// Next-PC operation encodings shared by the next-PC unit and the control FSM.
package npc_pkg;

  localparam int unsigned NPC_OP_W = 3;

  typedef enum logic [NPC_OP_W-1:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JMPR   = 3'b011,
    NPC_JAL    = 3'b100,
    NPC_RET    = 3'b101,
    NPC_EXC    = 3'b110
  } npc_op_e;

endpackage

// File: rtl/npc_ras_stack.sv
// Circular return-address stack: top pointer, saturating count, and
// one-cycle overflow/underflow pulses.
module npc_ras_stack #(
  parameter int unsigned DATA_W = 30,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_top,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_ovf,
  output logic              o_unf
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              r_unf;
  logic [PTR_W-1:0]  w_top_inc;
  logic [PTR_W-1:0]  w_top_dec;

  assign w_top_inc = r_top + PTR_W'(1);
  assign w_top_dec = r_top - PTR_W'(1);
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CNT_W'(DEPTH));
  assign o_top     = r_mem[r_top];
  assign o_ovf     = r_ovf;
  assign o_unf     = r_unf;

  // Entry contents need no reset; validity is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (rst && !i_flush && i_push) begin
      r_mem[w_top_inc] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_top <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (i_flush) begin
        r_cnt <= '0;
      end else if (i_push) begin
        r_top <= w_top_inc;
        if (o_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (i_pop) begin
        if (o_empty) begin
          r_unf <= 1'b1;
        end else begin
          r_top <= w_top_dec;
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/npc_ras_unit.sv
// Next-PC unit: PC register, target mux and return-address stack.
// Optional macro NPC_RAS_CHECK_EN adds ras_mis and makes RET follow jmpr.
module npc_ras_unit
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_en,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic                br_taken,
  input  logic [25:0]         imm,
  input  logic [ADDR_W-3:0]   jmpr,
  output logic [ADDR_W-3:0]   pc,
  output logic [ADDR_W-3:0]   npc,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_ovf,
  output logic                ras_unf
`ifdef NPC_RAS_CHECK_EN
  ,
  output logic                ras_mis
`endif
);

  localparam int unsigned PW = ADDR_W - 2;

  logic [PW-1:0] r_pc;
  logic [PW-1:0] w_npc;
  logic [PW-1:0] w_plus1;
  logic [PW-1:0] w_sext;
  logic [PW-1:0] w_jump;
  logic [PW-1:0] w_ras_top;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;

  assign w_plus1 = r_pc + PW'(1);
  assign w_sext  = {{(PW-16){imm[15]}}, imm[15:0]};
  // Mask form keeps the region bits valid even when PW equals 26.
  assign w_jump  = (r_pc & ~PW'(26'h3FF_FFFF)) | PW'(imm);

  always_comb begin
    w_npc   = w_plus1;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_flush = 1'b0;
    case (npc_op)
      NPC_BRANCH: if (br_taken) w_npc = r_pc + w_sext;
      NPC_JUMP:   w_npc = w_jump;
      NPC_JMPR:   w_npc = jmpr;
      NPC_JAL: begin
        w_npc  = w_jump;
        w_push = pc_en;
      end
      NPC_RET: begin
`ifdef NPC_RAS_CHECK_EN
        w_npc = jmpr;
`else
        w_npc = ras_empty ? jmpr : w_ras_top;
`endif
        w_pop = pc_en;
      end
      NPC_EXC: begin
        w_npc   = EXC_VEC[ADDR_W-1:2];
        w_flush = pc_en;
      end
      default: w_npc = w_plus1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= RESET_PC[ADDR_W-1:2];
    end else if (pc_en) begin
      r_pc <= w_npc;
    end
  end

`ifdef NPC_RAS_CHECK_EN
  logic r_mis;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mis <= 1'b0;
    end else begin
      r_mis <= w_pop && !ras_empty && (w_ras_top != jmpr);
    end
  end

  assign ras_mis = r_mis;
`endif

  assign pc  = r_pc;
  assign npc = w_npc;

  npc_ras_stack #(
    .DATA_W (PW),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (w_plus1),
    .o_top   (w_ras_top),
    .o_empty (ras_empty),
    .o_full  (ras_full),
    .o_ovf   (ras_ovf),
    .o_unf   (ras_unf)
  );

endmodule
